// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - operand/result bundle between control unit and mul_div_unit
// master drives requests and operands; slave (the unit) returns status and results.
interface mul_div_unit_if #(parameter int WIDTH = 16);
  logic             start;
  logic             op_div;
  logic             op_signed;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op_div, op_signed, operand_a, operand_b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op_div, op_signed, operand_a, operand_b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiply / restoring divide, one bit per clock
// Signed operation is compiled in only when MDU_SIGNED_EN is defined.
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           reset_n,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_div;
  logic [WIDTH-1:0]     r_res_lo, r_res_hi;
  logic                 r_dbz;
  logic                 w_load, w_last;
  logic [WIDTH:0]       w_sum, w_rem_sh;
  logic [WIDTH-1:0]     w_rem_sub;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b, w_fin_lo, w_fin_hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_load      = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: if (r_cnt == CW'(WIDTH - 1)) begin
        w_last      = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_load      = bus.start;
        w_state_nxt = bus.start ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Multiply keeps the multiplier in the low half; divide keeps {remainder, dividend}.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opnd;
    if (r_div) begin
      if (w_rem_sh >= {1'b0, r_opnd}) w_acc_nxt = {w_rem_sub, r_acc[WIDTH-2:0], 1'b1};
      else                            w_acc_nxt = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else if (r_acc[0]) begin
      w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    end else begin
      w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
    end
  end

`ifdef MDU_SIGNED_EN
  logic w_sa, w_sb;
  logic r_neg_q, r_neg_r;

  assign w_sa    = bus.op_signed & bus.operand_a[WIDTH-1];
  assign w_sb    = bus.op_signed & bus.operand_b[WIDTH-1];
  assign w_mag_a = w_sa ? -bus.operand_a : bus.operand_a;
  assign w_mag_b = w_sb ? -bus.operand_b : bus.operand_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_load) begin
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
    end
  end

  // A zero divisor keeps the raw all-ones quotient; the remainder sign fix restores the dividend.
  always_comb begin
    if (r_div) begin
      w_fin_lo = (r_neg_q && (r_opnd != '0)) ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
      w_fin_hi = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
    end else begin
      {w_fin_hi, w_fin_lo} = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    end
  end
`else
  logic w_unused;

  assign w_unused = bus.op_signed;
  assign w_mag_a  = bus.operand_a;
  assign w_mag_b  = bus.operand_b;
  assign w_fin_lo = w_acc_nxt[WIDTH-1:0];
  assign w_fin_hi = w_acc_nxt[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_div    <= 1'b0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_dbz    <= 1'b0;
    end else if (w_load) begin
      r_cnt  <= '0;
      r_div  <= bus.op_div;
      r_acc  <= {{WIDTH{1'b0}}, (bus.op_div ? w_mag_a : w_mag_b)};
      r_opnd <= bus.op_div ? w_mag_b : w_mag_a;
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_nxt;
      if (w_last) begin
        r_res_lo <= w_fin_lo;
        r_res_hi <= w_fin_hi;
        r_dbz    <= r_div & (r_opnd == '0);
      end
    end
  end

  assign bus.busy        = (r_state == RUN);
  assign bus.done        = (r_state == DONE);
  assign bus.result_lo   = r_res_lo;
  assign bus.result_hi   = r_res_hi;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle 16-bit multiply/divide unit that sits directly downstream of the register file. It consumes the two register read ports as operands and produces a 32-bit result for write-back: the low half goes to the general write-data path, the high half to the dedicated R0 write path. Operations run iteratively, one bit per clock, using shift-add multiply and restoring divide, under a start/busy/done handshake driven by the control unit.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 4; the iteration counter is $clog2(WIDTH) bits wide.

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- op_div  in  1  0 = multiply, 1 = divide; sampled with start
- op_signed  in  1  two's-complement operation; honoured only with MDU_SIGNED_EN
- operand_a  in  WIDTH  multiplicand / dividend; sampled with start
- operand_b  in  WIDTH  multiplier / divisor; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result valid
- result_lo  out  WIDTH  product low half / quotient
- result_hi  out  WIDTH  product high half / remainder; destined for R0
- div_by_zero  out  1  last divide had operand_b = 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1: latch the operands and op, clear the iteration counter, go to RUN.
- RUN: one iteration per edge.
  - Multiply: if the accumulator LSB is set, add the multiplicand to the upper half, then shift right 1, keeping the carry.
  - Divide: shift {remainder, dividend} left 1. If remainder ≥ divisor, subtract the divisor and set the quotient bit to 1; otherwise set it to 0.
- After WIDTH iterations, go to DONE, load result_lo/result_hi, and update div_by_zero.
- DONE lasts one cycle, then goes to IDLE unless a new start arrives.
- start while busy=1 is ignored. Operand changes during RUN have no effect.
- Divide by zero: no special path. The natural restoring result is required: quotient all-ones (0xFFFF), remainder = dividend, div_by_zero=1.
- Multiply clears div_by_zero.
- result_lo, result_hi and div_by_zero hold until the next completion.

## Timing
- Reset values: busy=0, done=0, result_lo=0, result_hi=0, div_by_zero=0; state IDLE; internal accumulators cleared.
- start accepted at edge E0: busy=1 from E0 until E_WIDTH.
- At edge E_WIDTH (E16 for the default): results, done=1 and busy=0 all update together.
- done=0 at E_WIDTH+1.
- Latency from accepting edge to valid result: WIDTH+1 edges inclusive of E0.
- Back-to-back: start high in the DONE cycle is accepted at E_WIDTH+1, so busy=1 again; the done pulse is still exactly one cycle.
- reset_n asserted mid-RUN: immediate abort to the reset values. No done pulse; the old result is lost.

## Configuration
- MDU_SIGNED_EN defined (signed support compiled in):
  - When op_signed=1, operands are converted to magnitudes at load and the unsigned iteration runs as usual.
  - At completion, the product is negated when the operand signs differ.
  - Quotient sign = sign_a XOR sign_b; remainder sign = sign of the dividend.
  - Divide by zero returns quotient 0xFFFF and remainder = original dividend, unmodified.
  - 0x8000 / 0xFFFF returns quotient 0x8000, remainder 0x0000.
  - Latency is unchanged.
- MDU_SIGNED_EN undefined: op_signed is ignored and all operations are unsigned. No sign logic is synthesised.

## Test plan
- Multiply 0x00FF × 0x0051 → result_hi=0x0000, result_lo=0x50AF, div_by_zero=0; done rises exactly 16 edges after the start edge, busy falls on the same edge.
- Unsigned multiply 0xFFFF × 0x0002 → hi=0x0001, lo=0xFFFE. With MDU_SIGNED_EN and op_signed=1 → hi=0xFFFF, lo=0xFFFE.
- Divide 0x6666 / 0x0011 → lo=0x0606, hi=0x0000. Then back-to-back start in the DONE cycle with 0x3099 / 0x0002 → lo=0x184C, hi=0x0001, with exactly two single-cycle done pulses.
- Divide 0xCCCC / 0x0000 → lo=0xFFFF, hi=0xCCCC, div_by_zero=1. A following multiply clears div_by_zero.
- Signed divide (macro on) 0xFFF9 / 0x0002 → lo=0xFFFD, hi=0xFFFF. Signed 0x8000 / 0xFFFF → lo=0x8000, hi=0x0000.
- Two robustness checks:
  - A start pulse and operand changes during RUN do not alter the in-flight result.
  - reset_n low at iteration 8 → all outputs 0 immediately, no done pulse, and a fresh start afterwards completes normally.
